// File: rtl/clic_gateway.sv
// -----------------------------------------------------------------------------
// clic_gateway
//
// Per-source interrupt gateway placed directly in front of the CLIC target
// arbiter. For each source it:
//   - synchronises the raw interrupt line,
//   - applies the source polarity,
//   - applies the trigger mode (level follows the line; edge latches),
//   - holds the pending bit that feeds the arbiter.
// Edge-mode pending bits are cleared by the arbiter's claim pulse and can be
// written by software. Level-mode sources ignore claim and software writes.
//
// Parameters
//   N_SOURCE    number of interrupt sources (>= 2)
//   SyncStages  synchroniser depth on intr_src_i; 0 = inputs already synchronous
//
// Ports
//   clk_i       clock (single domain)
//   rst_ni      asynchronous active-low reset
//   intr_src_i  raw interrupt lines, may be asynchronous to clk_i
//   le_i        trigger mode per source: 1 = edge, 0 = level
//   pol_i       polarity per source: 0 = active-high / rising, 1 = active-low / falling
//   ip_we_i     one-cycle software write strobe per pending bit
//   ip_wdata_i  software write data, valid with ip_we_i
//   claim_i     one-cycle claim pulse from the arbiter, at most one bit set
//   ip_o        registered pending bits to the arbiter
// -----------------------------------------------------------------------------
module clic_gateway #(
  parameter int N_SOURCE   = 256,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] ip_we_i,
  input  logic [N_SOURCE-1:0] ip_wdata_i,
  input  logic [N_SOURCE-1:0] claim_i,
  output logic [N_SOURCE-1:0] ip_o
);

  // Every source gets an identical, fully independent slice of logic.
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    logic s;         // synchronised raw line (before polarity)
    logic prev_q;    // previous synchronised raw value, for edge detection
    logic ip_q;      // pending bit
    logic edge_hit;  // active edge seen this cycle
    logic ip_d;

    if (SyncStages == 0) begin : g_bypass
      assign s = intr_src_i[i];
    end else begin : g_sync
      logic [SyncStages-1:0] sync_q;

      // NOTE: every flop, including the synchroniser chain, is cleared by the
      // asynchronous reset so that no stale edge survives a reset.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sync_q <= '0;
        end else begin
          // NOTE: non-blocking assignments make this a true shift chain; with
          // blocking ones the input would race through every stage in one edge.
          sync_q[0] <= intr_src_i[i];
          for (int k = 1; k < SyncStages; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SyncStages-1];
    end

    // prev_q holds the raw (pre-polarity) value, so flipping pol_i on a static
    // line compares the same raw value twice and never fakes an edge.
    assign edge_hit = pol_i[i] ? (prev_q & ~s) : (~prev_q & s);

    // Edge mode priority: new edge > software write > claim clear. The edge is
    // OR-ed in last so that it can never be masked by a claim or a write of 0.
    // Level mode simply tracks the polarity-corrected line; switching from
    // level to edge therefore keeps the last level value until claimed.
    assign ip_d = le_i[i]
                ? (edge_hit | (ip_we_i[i] ? ip_wdata_i[i] : (ip_q & ~claim_i[i])))
                : (s ^ pol_i[i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
        ip_q   <= 1'b0;
      end else begin
        prev_q <= s;
        ip_q   <= ip_d;
      end
    end

    // Registered output: no combinational path from any input to ip_o.
    assign ip_o[i] = ip_q;
  end

endmodule

// File: doc/clic_gateway.md
# clic_gateway

Per-source interrupt gateway sitting directly upstream of the CLIC target arbiter. It synchronises raw interrupt lines and applies per-source polarity and trigger mode (level or edge). It holds the per-source pending bits (`ip`) that feed the arbiter, clears edge-pending bits on the arbiter's claim pulse, and accepts software writes to pending bits from the register file.

## Interface
Parameters:
- `N_SOURCE`, 256: number of interrupt sources; must be ≥ 2.
- `SyncStages`, 2: synchroniser depth on `intr_src_i`; 0 = inputs already synchronous (no flops).

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `intr_src_i`  in  N_SOURCE  raw interrupt lines, may be asynchronous.
- `le_i`  in  N_SOURCE  trigger mode per source: 1 = edge, 0 = level.
- `pol_i`  in  N_SOURCE  polarity: 0 = active-high / rising edge, 1 = active-low / falling edge.
- `ip_we_i`  in  N_SOURCE  software write strobe to pending bit, one cycle.
- `ip_wdata_i`  in  N_SOURCE  software write data, valid with `ip_we_i`.
- `claim_i`  in  N_SOURCE  one-cycle claim pulse from arbiter; at most one bit set.
- `ip_o`  out  N_SOURCE  registered pending bits to arbiter `ip` input.

## Operation
- Synchroniser: `SyncStages` flops per source, all reset to 0. Output `s[i]` (equals `intr_src_i[i]` when `SyncStages` = 0).
- Edge detect:
  - `prev_q[i] <= s[i]` every cycle; reset 0.
  - `edge[i] = pol_i[i] ? (prev_q[i] & ~s[i]) : (~prev_q[i] & s[i])`.
  - `prev_q` stores the pre-polarity value, so a change of `pol_i` never creates an edge by itself.
- Level mode (`le_i[i]` = 0):
  - `ip_q[i] <= s[i] ^ pol_i[i]` every cycle.
  - `claim_i`, `ip_we_i` and `ip_wdata_i` are ignored for that source.
- Edge mode (`le_i[i]` = 1): `ip_q[i] <= edge[i] | (ip_we_i[i] ? ip_wdata_i[i] : (ip_q[i] & ~claim_i[i]))`.
- Priority in edge mode: new edge > software write > claim clear. A new edge is never lost, even when it coincides with a claim or a write of 0.
- Mode switch: `le_i` / `pol_i` changes take effect on the next clock edge.
  - Level → edge: `ip_q` keeps its current value. It then holds until claimed or written.
  - Edge → level: `ip_q` follows the level on the next clock edge.
- `ip_o = ip_q`. There is no combinational path from any input to `ip_o`.
- Sources are fully independent. Per-source logic is generated N_SOURCE times and contains no cross-source arithmetic.

## Timing
- Reset: all sync flops, `prev_q` and `ip_q` are 0, so `ip_o` = 0 while `rst_ni` is low. Assertion mid-operation clears everything immediately (asynchronously), including pending edges.
- Input-to-`ip_o` latency: an input change sampled at clock edge k appears on `ip_o` after edge k+`SyncStages`. This is `SyncStages`+1 edges from the first capture. With `SyncStages` = 2: 3 cycles. Latency is the same for level set, level clear and edge set.
- Claim: `claim_i[i]` high in cycle n clears `ip_o[i]` from cycle n+1, unless an edge or write-1 occurs in cycle n.
- Software write: visible on `ip_o` the cycle after `ip_we_i`.
- Reset release with a source already at its active level:
  - Level mode: pending after the latency above.
  - Edge mode, `pol_i` = 0: one rising edge is detected, because `prev_q` resets to 0.
  - Edge mode, `pol_i` = 1: no edge is detected.
- Input pulses shorter than one clock period may be missed; this is an accepted limitation.
- Back-to-back edges before a claim collapse into a single pending bit. There is no edge counting.

## Test plan
- Level, `SyncStages`=2, `pol`=0: src[3] rises at cycle 0 → `ip_o[3]`=1 from cycle 3. src[3] falls at cycle 10 → `ip_o[3]`=0 from cycle 13. `claim_i[3]` pulse at cycle 5 → no effect.
- Edge, `pol`=1: src[7] falls at cycle 0 → `ip_o[7]`=1 from cycle 3 and stays high after src[7] returns high. `claim_i[7]` at cycle 8 → `ip_o[7]`=0 at cycle 9.
- Simultaneous events, edge mode src[1]:
  - Edge reaches detect in the same cycle as `claim_i[1]` → `ip_o[1]` stays 1.
  - Edge in the same cycle as write 0 → `ip_o[1]`=1.
  - Write 1 in the same cycle as claim → 1.
- Software, edge mode src[0]: write 1 → `ip_o[0]`=1 next cycle. Write 0 → 0. Writes to a level-mode source do not change `ip_o`.
- Polarity/mode changes: toggle `pol_i[2]` with src[2] static → no edge pending. Switch src[4] level→edge while high → `ip_o[4]` stays 1 until claimed.
- Reset mid-operation with all `ip_o` = 1 → `ip_o` = 0 immediately. After release, with src[5]=1, edge mode, `pol`=0 → `ip_o[5]`=1 after 3 cycles.
